// File: rtl/ascon_host_pkg.sv
// Shared types and helpers for the Ascon serial host: FSM states, PRNG taps, frame sizing.
package ascon_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_GAP,
    ST_READ,
    ST_DONE
  } hostState_t;

  // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Fresh random bits consumed by the core per cycle
  localparam int RND_W = 17;

  // Largest of three widths and the fixed 128-bit nonce/tag width
  function automatic int maxWidth(input int a, input int b, input int c);
    int m;
    m = 128;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ascon_host_lfsr.sv
// 32-bit Galois LFSR supplying the masking randomness; advances only while enabled.
module ascon_prng_lfsr
  import ascon_host_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_5EED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [RND_W-1:0] rnd
);

  logic [31:0] lfsrReg;

  // Shift right, folding the tap mask in whenever a one drops out of bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsrReg <= SEED;
    end else if (en) begin
      lfsrReg <= (lfsrReg >> 1) ^ (lfsrReg[0] ? LFSR_TAPS : 32'h0);
    end
  end

  assign rnd = lfsrReg[RND_W-1:0];

endmodule

// File: rtl/ascon_serial_host.sv
// Host-side driver for the bit-serial Ascon core: serial load, start strobe, wait, serial read-back.
module ascon_serial_host
  import ascon_host_pkg::*;
#(
  parameter int          K          = 128,
  parameter int          L          = 40,
  parameter int          Y          = 40,
  parameter int          START_HOLD = 3,
  parameter int          READ_GAP   = 2,
  parameter int          TIMEOUT    = 4096,
  parameter logic [31:0] SEED       = 32'hACE1_5EED
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [K-1:0]   key_in,
  input  logic [127:0]   nonce_in,
  input  logic [L-1:0]   ad_in,
  input  logic [Y-1:0]   pt_in,
  output logic           busy,
  output logic           done,
  output logic           timeout,
  output logic [Y-1:0]   ct_out,
  output logic [127:0]   tag_out,
  output logic [31:0]    cycles_out,
  output logic [2:0]     keyxSO,
  output logic [2:0]     noncexSO,
  output logic [2:0]     associated_dataxSO,
  output logic [2:0]     plain_textxSO,
  output logic [6:0]     r_64xSO,
  output logic           r_128xSO,
  output logic           r_ptxSO,
  output logic           encryption_startxSO,
  input  logic           cipher_textxSI,
  input  logic           tagxSI,
  input  logic           encryption_readyxSI
);

  localparam int MAX     = maxWidth(K, L, Y);
  localparam int CNT_MAX = maxWidth(MAX, START_HOLD, READ_GAP);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LOAD_LAST  = CW'(MAX - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(READ_GAP - 1);
  localparam logic [CW-1:0] READ_LAST  = CW'(MAX - 1);
  localparam logic [CW-1:0] CT_LIM     = CW'(Y);
  localparam logic [CW-1:0] TAG_LIM    = CW'(128);
  localparam logic [31:0]   WAIT_LAST  = 32'(START_HOLD + TIMEOUT - 1);

  hostState_t       stateReg;
  logic [CW-1:0]    bitCnt;
  logic [31:0]      cycCnt;
  logic [31:0]      cycInc;
  logic [K-1:0]     keySh;
  logic [127:0]     nonceSh;
  logic [L-1:0]     adSh;
  logic [Y-1:0]     ptSh;
  logic [Y-1:0]     ctSh;
  logic [Y-1:0]     ctShNext;
  logic [127:0]     tagSh;
  logic [127:0]     tagShNext;
  logic             loadPhase;
  logic             rndPhase;
  logic [RND_W-1:0] rndRaw;
  logic [RND_W-1:0] rnd;

  assign loadPhase = (stateReg == ST_LOAD);
  assign rndPhase  = (stateReg == ST_LOAD) || (stateReg == ST_START) || (stateReg == ST_WAIT);

  ascon_prng_lfsr #(.SEED(SEED)) uPrng (
    .clk (clk),
    .rst (rst),
    .en  (rndPhase),
    .rnd (rndRaw)
  );

  // Randomness is only exposed while the core is loading or computing
  assign rnd                 = rndPhase ? rndRaw : '0;
  assign r_128xSO            = rnd[16];
  assign r_ptxSO             = rnd[15];
  assign r_64xSO             = rnd[14:8];
  assign keyxSO              = {rnd[7:6], loadPhase & keySh[K-1]};
  assign associated_dataxSO  = {rnd[5:4], loadPhase & adSh[L-1]};
  assign plain_textxSO       = {rnd[3:2], loadPhase & ptSh[Y-1]};
  assign noncexSO            = {rnd[1:0], loadPhase & nonceSh[127]};
  assign encryption_startxSO = (stateReg == ST_START);

  // Saturating increment shared by the start/wait cycle counter
  assign cycInc = (cycCnt == 32'hFFFF_FFFF) ? cycCnt : cycCnt + 32'd1;

  // Arrival i lands at bit i once the first Y (or 128) arrivals have shifted in from the top
  assign ctShNext  = (bitCnt < CT_LIM)  ? {cipher_textxSI, ctSh[Y-1:1]}  : ctSh;
  assign tagShNext = (bitCnt < TAG_LIM) ? {tagxSI, tagSh[127:1]}         : tagSh;

  // Sequencer: accept, shift out, strobe start, wait for ready, shift in, publish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= ST_IDLE;
      bitCnt     <= '0;
      cycCnt     <= '0;
      keySh      <= '0;
      nonceSh    <= '0;
      adSh       <= '0;
      ptSh       <= '0;
      ctSh       <= '0;
      tagSh      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      ct_out     <= '0;
      tag_out    <= '0;
      cycles_out <= '0;
    end else begin
      done <= 1'b0;
      case (stateReg)
        ST_IDLE: begin
          if (go) begin
            keySh    <= key_in;
            nonceSh  <= nonce_in;
            adSh     <= ad_in;
            ptSh     <= pt_in;
            ctSh     <= '0;
            tagSh    <= '0;
            bitCnt   <= '0;
            busy     <= 1'b1;
            timeout  <= 1'b0;
            stateReg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          keySh   <= {keySh[K-2:0], 1'b0};
          nonceSh <= {nonceSh[126:0], 1'b0};
          adSh    <= {adSh[L-2:0], 1'b0};
          ptSh    <= {ptSh[Y-2:0], 1'b0};
          if (bitCnt == LOAD_LAST) begin
            bitCnt   <= '0;
            cycCnt   <= '0;
            stateReg <= ST_START;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        ST_START: begin
          cycCnt <= cycInc;
          if (bitCnt == START_LAST) begin
            bitCnt   <= '0;
            stateReg <= ST_WAIT;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        ST_WAIT: begin
          cycCnt <= cycInc;
          if (encryption_readyxSI) begin
            cycles_out <= cycInc;
            bitCnt     <= '0;
            stateReg   <= ST_GAP;
          end else if (cycCnt == WAIT_LAST) begin
            timeout  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            stateReg <= ST_DONE;
          end
        end
        ST_GAP: begin
          if (bitCnt == GAP_LAST) begin
            bitCnt   <= '0;
            stateReg <= ST_READ;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        ST_READ: begin
          ctSh  <= ctShNext;
          tagSh <= tagShNext;
          if (bitCnt == READ_LAST) begin
            ct_out   <= ctShNext;
            tag_out  <= tagShNext;
            busy     <= 1'b0;
            done     <= 1'b1;
            bitCnt   <= '0;
            stateReg <= ST_DONE;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        ST_DONE: begin
          stateReg <= ST_IDLE;
        end
        default: begin
          stateReg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
